lane_vrf_write_sink: RTL

Receiving end of a lane's VRF write-request stream. Accepts ready/valid write requests (vd, byte mask, data, last, instructionIndex) from the lane's stage-3 pipe and buffers them in a small FIFO. Commits each one to the VRF bank write port, yielding to read-port conflicts. Keeps a per-instruction count of committed writes and reports each instruction's completion when its `last` write commits.

---
 rtl/lane_vrf_write_sink.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lane_vrf_write_sink.sv
// Receiving end of a lane's VRF write-request stream. Buffers requests, commits them to the
// bank write port when no read conflict is present, and tracks per-instruction write counts.
module lane_vrf_write_sink #(
  parameter int DEPTH       = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int VD_WIDTH    = 5,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      vrfWriteRequest_valid,
  output logic                      vrfWriteRequest_ready,
  input  logic [VD_WIDTH-1:0]       vrfWriteRequest_bits_vd,
  input  logic [DATA_WIDTH/8-1:0]   vrfWriteRequest_bits_mask,
  input  logic [DATA_WIDTH-1:0]     vrfWriteRequest_bits_data,
  input  logic                      vrfWriteRequest_bits_last,
  input  logic [2:0]                vrfWriteRequest_bits_instructionIndex,
  input  logic                      readConflict,
  output logic                      vrfWrite_valid,
  output logic [VD_WIDTH-1:0]       vrfWrite_addr,
  output logic [DATA_WIDTH/8-1:0]   vrfWrite_mask,
  output logic [DATA_WIDTH-1:0]     vrfWrite_data,
  output logic                      writeDone_valid,
  output logic [2:0]                writeDone_instructionIndex,
  output logic [COUNT_WIDTH-1:0]    writeDone_count,
  output logic                      idle
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_WIDTH  = PTR_WIDTH + 1;
  localparam int NUM_SLOTS  = 8;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [OCC_WIDTH-1:0]   OCC_FULL   = OCC_WIDTH'(DEPTH);
  localparam logic [OCC_WIDTH-1:0]   OCC_ZERO   = {OCC_WIDTH{1'b0}};
  localparam logic [OCC_WIDTH-1:0]   OCC_ONE    = {{(OCC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0]   PTR_ZERO   = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE    = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    logic [COUNT_WIDTH-1:0] result;
    if (value == COUNT_MAX) begin
      result = value;
    end else begin
      result = value + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
    logic [PTR_WIDTH-1:0] result;
    if (ptr == PTR_LAST) begin
      result = PTR_ZERO;
    end else begin
      result = ptr + PTR_ONE;
    end
    return result;
  endfunction

  logic [VD_WIDTH-1:0]    vd_mem_r   [DEPTH];
  logic [MASK_WIDTH-1:0]  mask_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem_r [DEPTH];
  logic                   last_mem_r [DEPTH];
  logic [2:0]             idx_mem_r  [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr_r;
  logic [PTR_WIDTH-1:0]   rd_ptr_r;
  logic [OCC_WIDTH-1:0]   occ_r;

  logic [COUNT_WIDTH-1:0] cnt_r [NUM_SLOTS];

  logic                   wr_valid_r;
  logic [VD_WIDTH-1:0]    wr_addr_r;
  logic [MASK_WIDTH-1:0]  wr_mask_r;
  logic [DATA_WIDTH-1:0]  wr_data_r;
  logic                   done_valid_r;
  logic [2:0]             done_idx_r;
  logic [COUNT_WIDTH-1:0] done_count_r;

  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic [VD_WIDTH-1:0]    head_vd_s;
  logic [MASK_WIDTH-1:0]  head_mask_s;
  logic [DATA_WIDTH-1:0]  head_data_s;
  logic                   head_last_s;
  logic [2:0]             head_idx_s;
  logic                   head_writes_s;
  logic [COUNT_WIDTH-1:0] head_cnt_inc_s;

  // Ready comes from the occupancy register alone, so a full FIFO refuses even while popping.
  assign full_s  = (occ_r == OCC_FULL);
  assign empty_s = (occ_r == OCC_ZERO);
  assign push_s  = vrfWriteRequest_valid & ~full_s;
  assign pop_s   = ~empty_s & ~readConflict;

  assign head_vd_s      = vd_mem_r[rd_ptr_r];
  assign head_mask_s    = mask_mem_r[rd_ptr_r];
  assign head_data_s    = data_mem_r[rd_ptr_r];
  assign head_last_s    = last_mem_r[rd_ptr_r];
  assign head_idx_s     = idx_mem_r[rd_ptr_r];
  assign head_writes_s  = |head_mask_s;
  assign head_cnt_inc_s = sat_inc(cnt_r[head_idx_s]);

  // Request storage: write the tail entry on every accepted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vd_mem_r[i]   <= {VD_WIDTH{1'b0}};
        mask_mem_r[i] <= {MASK_WIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
        last_mem_r[i] <= 1'b0;
        idx_mem_r[i]  <= 3'd0;
      end
    end else if (push_s) begin
      vd_mem_r[wr_ptr_r]   <= vrfWriteRequest_bits_vd;
      mask_mem_r[wr_ptr_r] <= vrfWriteRequest_bits_mask;
      data_mem_r[wr_ptr_r] <= vrfWriteRequest_bits_data;
      last_mem_r[wr_ptr_r] <= vrfWriteRequest_bits_last;
      idx_mem_r[wr_ptr_r]  <= vrfWriteRequest_bits_instructionIndex;
    end else begin
      vd_mem_r[wr_ptr_r] <= vd_mem_r[wr_ptr_r];
    end
  end

  // Circular pointers and occupancy counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Per-instruction commit counters; a committing last entry restarts its slot from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cnt_r[i] <= COUNT_ZERO;
      end
    end else if (pop_s) begin
      if (head_last_s) begin
        cnt_r[head_idx_s] <= COUNT_ZERO;
      end else begin
        cnt_r[head_idx_s] <= head_cnt_inc_s;
      end
    end else begin
      cnt_r[head_idx_s] <= cnt_r[head_idx_s];
    end
  end

  // Bank write port: zero-mask entries pop without issuing a write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {VD_WIDTH{1'b0}};
      wr_mask_r  <= {MASK_WIDTH{1'b0}};
      wr_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_valid_r <= pop_s & head_writes_s;
      if (pop_s && head_writes_s) begin
        wr_addr_r <= head_vd_s;
        wr_mask_r <= head_mask_s;
        wr_data_r <= head_data_s;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_mask_r <= wr_mask_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  // Completion report, aligned with the write strobe of the same entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_valid_r <= 1'b0;
      done_idx_r   <= 3'd0;
      done_count_r <= COUNT_ZERO;
    end else begin
      done_valid_r <= pop_s & head_last_s;
      if (pop_s && head_last_s) begin
        done_idx_r   <= head_idx_s;
        done_count_r <= head_cnt_inc_s;
      end else begin
        done_idx_r   <= done_idx_r;
        done_count_r <= done_count_r;
      end
    end
  end

  assign vrfWriteRequest_ready      = ~full_s;
  assign idle                       = empty_s & ~wr_valid_r;
  assign vrfWrite_valid             = wr_valid_r;
  assign vrfWrite_addr              = wr_addr_r;
  assign vrfWrite_mask              = wr_mask_r;
  assign vrfWrite_data              = wr_data_r;
  assign writeDone_valid            = done_valid_r;
  assign writeDone_instructionIndex = done_idx_r;
  assign writeDone_count            = done_count_r;

endmodule
